// File: rtl/video_timing_ctrl.sv
// Raster timing controller: hcount/vcount, syncs, data-enable and line/frame markers
// with frame-aligned start/stop. Defaults to 1080p (2200 x 1125 total).
module video_timing_ctrl #(
    parameter int   COUNTER_WIDTH = 12,
    parameter int   H_ACTIVE      = 1920,
    parameter int   H_FP          = 88,
    parameter int   H_SYNC        = 44,
    parameter int   H_BP          = 148,
    parameter int   V_ACTIVE      = 1080,
    parameter int   V_FP          = 4,
    parameter int   V_SYNC        = 5,
    parameter int   V_BP          = 36,
    parameter logic SYNC_POL      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic [COUNTER_WIDTH-1:0] hcount,
    output logic [COUNTER_WIDTH-1:0] vcount,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     de,
    output logic                     line_start,
    output logic                     frame_start,
    output logic                     running,
    output logic [15:0]              frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2 ** COUNTER_WIDTH || V_TOTAL > 2 ** COUNTER_WIDTH) begin : g_width_check
        $error("video_timing_ctrl: H_TOTAL-1 or V_TOTAL-1 does not fit in COUNTER_WIDTH");
    end

    localparam logic [COUNTER_WIDTH-1:0] H_LAST     = COUNTER_WIDTH'(H_TOTAL - 1);
    localparam logic [COUNTER_WIDTH-1:0] V_LAST     = COUNTER_WIDTH'(V_TOTAL - 1);
    localparam logic [COUNTER_WIDTH-1:0] H_ACT      = COUNTER_WIDTH'(H_ACTIVE);
    localparam logic [COUNTER_WIDTH-1:0] V_ACT      = COUNTER_WIDTH'(V_ACTIVE);
    localparam logic [COUNTER_WIDTH-1:0] HS_FIRST   = COUNTER_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [COUNTER_WIDTH-1:0] HS_LAST    = COUNTER_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COUNTER_WIDTH-1:0] VS_FIRST   = COUNTER_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [COUNTER_WIDTH-1:0] VS_LAST    = COUNTER_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [COUNTER_WIDTH-1:0] h_nxt;
    logic [COUNTER_WIDTH-1:0] v_nxt;
    logic                     last_h;
    logic                     last_v;
    logic                     fc_inc;
    logic                     run_nxt;
    logic                     hs_act;
    logic                     vs_act;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        fc_inc    = 1'b0;
        last_h    = (hcount == H_LAST);
        last_v    = (vcount == V_LAST);

        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            default: begin
                h_nxt  = last_h ? '0 : hcount + 1'b1;
                v_nxt  = last_h ? (last_v ? '0 : vcount + 1'b1) : vcount;
                fc_inc = last_h && last_v;
                // Stopping only takes effect at the last pixel, so frames are never cut short.
                if (enable)
                    state_nxt = RUN;
                else if (state == STOP_PEND && last_h && last_v)
                    state_nxt = IDLE;
                else
                    state_nxt = STOP_PEND;
            end
        endcase

        // Outputs are derived from the next counts so the registered flags line up with them.
        run_nxt = (state_nxt != IDLE);
        hs_act  = run_nxt && (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
        vs_act  = run_nxt && (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            de          <= run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
            line_start  <= run_nxt && (h_nxt == '0);
            frame_start <= run_nxt && (h_nxt == '0) && (v_nxt == '0);
            running     <= run_nxt;
            frame_cnt   <= frame_cnt + 16'(fc_inc);
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench: a default 1080p instance and a small SYNC_POL=0 instance run in
// lockstep against a behavioural raster model; directed checks cover the edges.
module tb_video_timing_ctrl;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        bit pol;
    } timing_t;

    typedef struct {
        int st;   // 0 idle, 1 run, 2 stop pending
        int h;
        int v;
        int fc;
    } model_t;

    localparam timing_t TD = '{1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1};
    localparam timing_t TS = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_d = 1'b0;
    logic en_s = 1'b0;

    logic [11:0] d_hcount, d_vcount, s_hcount, s_vcount;
    logic        d_hsync, d_vsync, d_de, d_line_start, d_frame_start, d_running;
    logic        s_hsync, s_vsync, s_de, s_line_start, s_frame_start, s_running;
    logic [15:0] d_frame_cnt, s_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    model_t      md, ms;
    logic [63:0] q_d[$];
    logic [63:0] q_s[$];

    always #5 clk = ~clk;

    video_timing_ctrl dut_d (
        .clk(clk), .rst(rst), .enable(en_d),
        .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
        .de(d_de), .line_start(d_line_start), .frame_start(d_frame_start),
        .running(d_running), .frame_cnt(d_frame_cnt)
    );

    video_timing_ctrl #(
        .COUNTER_WIDTH(12), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst), .enable(en_s),
        .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
        .de(s_de), .line_start(s_line_start), .frame_start(s_frame_start),
        .running(s_running), .frame_cnt(s_frame_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic [11:0] h, input logic [11:0] v,
                                         input logic hs, input logic vs, input logic de,
                                         input logic ls, input logic fs, input logic run,
                                         input logic [15:0] fc);
        return {18'b0, h, v, hs, vs, de, ls, fs, run, fc};
    endfunction

    function automatic model_t mnext(input model_t m, input timing_t t, input bit en);
        model_t n = m;
        int htot = t.ha + t.hfp + t.hs + t.hbp;
        int vtot = t.va + t.vfp + t.vs + t.vbp;
        bit last = (m.h == htot - 1) && (m.v == vtot - 1);
        if (m.st == 0) begin
            n.h = 0;
            n.v = 0;
            if (en) n.st = 1;
        end else begin
            n.h = m.h + 1;
            if (n.h == htot) begin
                n.h = 0;
                n.v = m.v + 1;
                if (n.v == vtot) begin
                    n.v  = 0;
                    n.fc = (m.fc + 1) % 65536;
                end
            end
            if (en)                      n.st = 1;
            else if (m.st == 2 && last)  n.st = 0;
            else                         n.st = 2;
        end
        return n;
    endfunction

    function automatic logic [63:0] expect_of(input model_t m, input timing_t t);
        bit run = (m.st != 0);
        bit hs  = run && m.h >= t.ha + t.hfp && m.h < t.ha + t.hfp + t.hs;
        bit vs  = run && m.v >= t.va + t.vfp && m.v < t.va + t.vfp + t.vs;
        return pack(12'(m.h), 12'(m.v), hs ? t.pol : !t.pol, vs ? t.pol : !t.pol,
                    run && m.h < t.ha && m.v < t.va, run && m.h == 0,
                    run && m.h == 0 && m.v == 0, run, 16'(m.fc));
    endfunction

    function automatic logic [63:0] obs_d();
        return pack(d_hcount, d_vcount, d_hsync, d_vsync, d_de, d_line_start,
                    d_frame_start, d_running, d_frame_cnt);
    endfunction

    function automatic logic [63:0] obs_s();
        return pack(s_hcount, s_vcount, s_hsync, s_vsync, s_de, s_line_start,
                    s_frame_start, s_running, s_frame_cnt);
    endfunction

    // Drive one cycle: model predicts, expectation queued, DUT compared after the edge.
    task automatic cycle(input bit es);
        en_s = es;
        md = mnext(md, TD, en_d);
        ms = mnext(ms, TS, en_s);
        q_d.push_back(expect_of(md, TD));
        q_s.push_back(expect_of(ms, TS));
        @(posedge clk);
        #1;
        check("d_sb", obs_d(), q_d.pop_front());
        check("s_sb", obs_s(), q_s.pop_front());
        if (d_running && d_vcount == 12'd0) begin
            case (d_hcount)
                12'd1919: check("d_de_1919", d_de, 1'b1);
                12'd1920: check("d_de_1920", d_de, 1'b0);
                12'd2007: check("d_hs_2007", d_hsync, 1'b0);
                12'd2008: check("d_hs_2008", d_hsync, 1'b1);
                12'd2051: check("d_hs_2051", d_hsync, 1'b1);
                12'd2052: check("d_hs_2052", d_hsync, 1'b0);
                default: ;
            endcase
        end
        if (d_hcount == 12'd0 && d_vcount == 12'd1)
            check("d_line_wrap", d_line_start, 1'b1);
    endtask

    task automatic reset_models();
        md = '{0, 0, 0, 0};
        ms = '{0, 0, 0, 0};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_models();
        #12;
        check("d_reset", obs_d(), pack(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        check("s_reset", obs_s(), pack(12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle(1'b0);

        en_d = 1'b1;
        cycle(1'b1);
        check("d_first", obs_d(), pack(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0));
        check("s_first", obs_s(), pack(12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0));

        // Small raster: first wrap, frame counter 0 -> 1.
        while (ms.fc < 1) cycle(1'b1);
        check("s_wrap_fs", s_frame_start, 1'b1);
        check("s_wrap_fc", s_frame_cnt, 16'd1);

        // Drop enable mid-frame: finishes the frame, then idles.
        while (ms.v != 2) cycle(1'b1);
        while (ms.st != 0) cycle(1'b0);
        check("s_stopped", obs_s(), pack(12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
        repeat (5) cycle(1'b0);

        // Drop, then re-raise before the frame ends: no interruption.
        cycle(1'b1);
        while (ms.v != 2) cycle(1'b1);
        while (ms.v != 4) cycle(1'b0);
        check("s_reraise_run", s_running, 1'b1);
        while (ms.fc < 3) cycle(1'b1);

        // Drop, then raise exactly on the last-pixel cycle: next frame starts normally.
        while (ms.v != 2) cycle(1'b1);
        while (!(ms.h == 13 && ms.v == 6)) cycle(1'b0);
        cycle(1'b1);
        check("s_last_px_fs", s_frame_start, 1'b1);
        check("s_last_px_run", s_running, 1'b1);

        // Keep the 1080p instance going past its first line wrap.
        while (!(md.v == 1 && md.h == 20)) cycle(1'b1);

        // Asynchronous reset mid-run, observed before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("d_async_rst", obs_d(), pack(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        check("s_async_rst", obs_s(), pack(12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        reset_models();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        en_d = 1'b0;
        repeat (3) cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
